// File: rtl/mips_pkg.sv
// Shared fetch-path definitions: FSM state encoding, PC step and default reset PC.
package mips_pkg;

  typedef enum logic [1:0] {
    StFetch  = 2'd0,
    StDrain  = 2'd1,
    StHalted = 2'd2
  } fetch_state_e;

  localparam logic [15:0] PcIncr         = 16'd2;
  localparam logic [15:0] ResetPcDefault = 16'h0000;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: DEPTH entries of {pc, instr}, in-order push/pop with a flush that empties it.
module fetch_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [31:0]            push_data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [31:0]            head_data_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     mem_q [DEPTH];

  // Pointer and occupancy update; flush wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push_i && !pop_i) begin
        count_d = count_q + CntW'(1);
      end else if (!push_i && pop_i) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  // Pointer/count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_data_o = mem_q[rd_ptr_q];
  assign count_o     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential fetches, buffers responses, handles redirect/halt.
// Optional perf counters (stall_cnt, flush_cnt) are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = ResetPcDefault
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  localparam int unsigned     CntW   = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  fetch_state_e    state_q, state_d;
  logic [15:0]     fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0] outst_q, outst_d;
  logic [CntW-1:0] drop_cnt_q, drop_cnt_d;
  logic            q_push, q_pop, q_flush;
  logic [31:0]     q_head;
  logic [CntW-1:0] q_count;
  logic [CntW:0]   in_use;
  logic            room;

  // Queue entries plus in-flight requests must stay below DEPTH so a push never overflows.
  assign in_use = {1'b0, q_count} + {1'b0, outst_q};
  assign room   = in_use < {1'b0, DepthC};

  // FSM next state, request issue, queue control and drop accounting.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    imem_req   = 1'b0;
    q_push     = 1'b0;
    q_flush    = 1'b0;
    if (redirect) begin
      // A response arriving this cycle is already dropped, so it is not counted again.
      q_flush    = 1'b1;
      fetch_pc_d = redirect_pc;
      drop_cnt_d = outst_q - CntW'(imem_rvalid);
      state_d    = (drop_cnt_d != '0) ? StDrain : StFetch;
    end else begin
      unique case (state_q)
        StFetch: begin
          imem_req = !rst && !halt && room;
          q_push   = imem_rvalid;
          if (imem_req) fetch_pc_d = fetch_pc_q + PcIncr;
          if (halt && (outst_q == '0)) state_d = StHalted;
        end
        StDrain: begin
          if (imem_rvalid) begin
            drop_cnt_d = drop_cnt_q - CntW'(1);
            if (drop_cnt_q == CntW'(1)) state_d = StFetch;
          end
        end
        StHalted: begin
          q_push = imem_rvalid;
          if (!halt) state_d = StFetch;
        end
        default: state_d = StFetch;
      endcase
    end
  end

  // Count of issued requests whose response has not yet returned.
  always_comb begin
    outst_d = outst_q;
    if (imem_req && !imem_rvalid) begin
      outst_d = outst_q + CntW'(1);
    end else if (!imem_req && imem_rvalid) begin
      outst_d = outst_q - CntW'(1);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StFetch;
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign q_pop = instr_valid && instr_ready && !redirect;

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .push_i      (q_push),
    .push_data_i ({fetch_pc_resp(), imem_rdata}),
    .pop_i       (q_pop),
    .flush_i     (q_flush),
    .head_data_o (q_head),
    .count_o     (q_count)
  );

  // Issuing address of the response now returning: requests are in order, so it trails fetch_pc.
  function automatic logic [15:0] fetch_pc_resp();
    return fetch_pc_q - {outst_q, 1'b0};
  endfunction

  assign imem_addr   = fetch_pc_q;
  assign instr_valid = (q_count != '0);
  assign instr       = instr_valid ? q_head[15:0]  : 16'h0000;
  assign instr_pc    = instr_valid ? q_head[31:16] : 16'h0000;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Saturating stall and redirect event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (instr_ready && !instr_valid && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (redirect && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  // Perf counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic against an in-order stream model.
module tb_fetch_unit;

  localparam int unsigned Depth = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        imem_req, imem_rvalid, instr_valid, instr_ready, redirect, halt;
  logic [15:0] imem_addr, imem_rdata, instr, instr_pc, redirect_pc;
  logic        req2, rvalid2, valid2;
  logic [15:0] addr2, rdata2, instr2, pc2;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt, stall_cnt2, flush_cnt2;
`endif

  fetch_unit #(
    .DEPTH    (Depth),
    .RESET_PC (16'h0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  fetch_unit #(
    .DEPTH    (Depth),
    .RESET_PC (16'hFFFC)
  ) dut_wrap (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (req2),
    .imem_addr   (addr2),
    .imem_rvalid (rvalid2),
    .imem_rdata  (rdata2),
    .instr_valid (valid2),
    .instr_ready (1'b1),
    .instr       (instr2),
    .instr_pc    (pc2),
    .redirect    (1'b0),
    .redirect_pc (16'h0000),
    .halt        (1'b0)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt2),
    .flush_cnt   (flush_cnt2)
`endif
  );

  typedef struct packed {
    logic [15:0] addr;
    int          due;
    int          ep;
  } pend_t;

  pend_t       pend[$];
  int          total = 0;
  int          bad = 0;
  int          cyc, mem_lat, last_due, epoch, occ;
  int          n_req = 0;
  int          n_del = 0;
  int          n_drop = 0;
  logic [15:0] exp_pc, exp_fetch;
  logic        s_req, s_valid, s_del;
  logic [15:0] s_addr, s_pc;
  logic        req2_prev;
  logic [15:0] addr2_prev;
  logic [15:0] wrap_pcs[$];
  logic [15:0] t1_pcs[$];
  logic        wrap_collect;

  // Memory contents: a fixed scramble of the address.
  function automatic logic [15:0] f(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5AC3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive memory responses, check outputs against the stream model, advance.
  task automatic step();
    pend_t rsp;
    pend_t e;
    logic  got;
    logic  ok;
    int    stale;
    got = 1'b0;
    rsp = '0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      rsp         = pend.pop_front();
      got         = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = f(rsp.addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 16'($urandom);
    end
    rvalid2 = req2_prev;
    rdata2  = f(addr2_prev);
    #4;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = instr_valid;
    s_pc    = instr_pc;
    s_del   = instr_valid && instr_ready && !redirect;
    chk("valid_vs_occupancy", instr_valid, occ > 0);
    if (instr_valid) begin
      chk("instr_pc", instr_pc, exp_pc);
      chk("instr", instr, f(exp_pc));
    end
    if (s_del) begin
      exp_pc += 16'd2;
      occ--;
      n_del++;
    end
    stale = 0;
    foreach (pend[i]) if (pend[i].ep != epoch) stale++;
    if (got && rsp.ep != epoch) stale++;
    ok = !redirect && !halt && (stale == 0) && ((pend.size() + int'(got) + occ) < int'(Depth));
    chk("req_allowed", imem_req && !ok, 1'b0);
    if (imem_req) begin
      chk("imem_addr", imem_addr, exp_fetch);
      last_due = (cyc + mem_lat > last_due + 1) ? cyc + mem_lat : last_due + 1;
      e.addr   = imem_addr;
      e.due    = last_due;
      e.ep     = epoch;
      pend.push_back(e);
      exp_fetch += 16'd2;
      n_req++;
    end
    if (got) begin
      if (rsp.ep == epoch && !redirect) occ++;
      else n_drop++;
    end
    if (redirect) begin
      epoch++;
      occ       = 0;
      exp_pc    = redirect_pc;
      exp_fetch = redirect_pc;
    end
    if (valid2) chk("wrap_instr", instr2, f(pc2));
    if (valid2 && wrap_collect && wrap_pcs.size() < 3) wrap_pcs.push_back(pc2);
    req2_prev  = req2;
    addr2_prev = addr2;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    halt        = 1'b0;
    instr_ready = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 16'h0000;
    rvalid2     = 1'b0;
    rdata2      = 16'h0000;
    pend.delete();
    occ        = 0;
    epoch      = 0;
    last_due   = -1;
    mem_lat    = 1;
    exp_pc     = 16'h0000;
    exp_fetch  = 16'h0000;
    req2_prev  = 1'b0;
    addr2_prev = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_instr_pc", instr_pc, 16'h0000);
    chk("rst_imem_addr", imem_addr, 16'h0000);
    chk("rst_wrap_req", req2, 1'b0);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_del(output logic found, output logic [15:0] pc);
    found = 1'b0;
    pc    = 16'h0000;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (s_del) begin
        found = 1'b1;
        pc    = s_pc;
      end
    end
  endtask

  initial begin
    int          first_valid;
    int          r0, d0, x0;
    logic        seen, found;
    logic [15:0] pc;
    logic [15:0] wrap_exp[3];

    // Reset release, 1-cycle memory, core always ready.
    wrap_collect = 1'b1;
    do_reset();
    instr_ready = 1'b1;
    first_valid = -1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0) begin
        chk("first_req", s_req, 1'b1);
        chk("first_addr", s_addr, 16'h0000);
      end
      if (s_valid && first_valid < 0) first_valid = i;
      if (s_del) t1_pcs.push_back(s_pc);
    end
    chk("first_valid_cycle", first_valid, 2);
    chk("t1_delivered", t1_pcs.size() >= 4, 1'b1);
    for (int k = 0; k < 4; k++) begin
      if (k < t1_pcs.size()) chk("t1_pc_seq", t1_pcs[k], 16'(2 * k));
    end
    wrap_exp[0] = 16'hFFFC;
    wrap_exp[1] = 16'hFFFE;
    wrap_exp[2] = 16'h0000;
    chk("wrap_count", wrap_pcs.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (k < wrap_pcs.size()) chk("wrap_pc_seq", wrap_pcs[k], wrap_exp[k]);
    end
    wrap_collect = 1'b0;

    // Core stalls for 10 cycles: only DEPTH requests may be issued.
    do_reset();
    r0 = n_req;
    for (int i = 0; i < 10; i++) step();
    chk("t2_requests", n_req - r0, 4);
    chk("t2_req_idle", s_req, 1'b0);
    instr_ready = 1'b1;
    d0 = n_del;
    for (int i = 0; i < 10; i++) step();
    chk("t2_resume", (n_del - d0) >= 4, 1'b1);

    // 3-cycle memory, redirect with three requests in flight.
    do_reset();
    instr_ready = 1'b1;
    mem_lat     = 3;
    seen        = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (pend.size() == 3) seen = 1'b1;
      else step();
    end
    chk("t3_three_outstanding", seen, 1'b1);
    x0          = n_drop;
    redirect    = 1'b1;
    redirect_pc = 16'h0100;
    step();
    redirect = 1'b0;
    wait_del(found, pc);
    chk("t3_found", found, 1'b1);
    chk("t3_first_pc", pc, 16'h0100);
    chk("t3_dropped", n_drop - x0, 3);

    // Second redirect while still draining.
    do_reset();
    instr_ready = 1'b1;
    mem_lat     = 3;
    seen        = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (pend.size() == 3) seen = 1'b1;
      else step();
    end
    chk("t4_three_outstanding", seen, 1'b1);
    x0          = n_drop;
    redirect    = 1'b1;
    redirect_pc = 16'h0100;
    step();
    redirect_pc = 16'h0200;
    step();
    redirect = 1'b0;
    wait_del(found, pc);
    chk("t4_found", found, 1'b1);
    chk("t4_first_pc", pc, 16'h0200);
    chk("t4_dropped", n_drop - x0, 3);

    // Halt with two entries queued.
    do_reset();
    step();
    step();
    halt = 1'b1;
    r0   = n_req;
    for (int i = 0; i < 6; i++) step();
    instr_ready = 1'b1;
    d0          = n_del;
    for (int i = 0; i < 4; i++) step();
    chk("t6_no_requests", n_req - r0, 0);
    chk("t6_delivered", n_del - d0, 2);
    halt = 1'b0;
    seen = 1'b0;
    pc   = 16'h0000;
    for (int i = 0; i < 6 && !seen; i++) begin
      step();
      if (s_req) begin
        seen = 1'b1;
        pc   = s_addr;
      end
    end
    chk("t6_resume", seen, 1'b1);
    chk("t6_resume_pc", pc, 16'h0004);

    // Random ready/halt/redirect traffic with variable memory latency.
    do_reset();
    d0 = n_del;
    for (int i = 0; i < 400; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      if (halt) halt = ($urandom_range(0, 3) != 0);
      else halt = ($urandom_range(0, 19) == 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = 16'($urandom) & 16'hFFFE;
      mem_lat     = $urandom_range(1, 3);
      step();
    end
    chk("rand_progress", (n_del - d0) > 20, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the prefetch queue entry count (power of two, 2..8).
REQ-002 SHALL have parameter RESET_PC, default 16'h0000, meaning the first fetch address after reset.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port imem_req  output  1  fetch request valid for the current cycle.
REQ-006 SHALL have port imem_addr  output  16  byte address of the requested instruction.
REQ-007 SHALL have port imem_rvalid  input  1  returned instruction valid; responses arrive in request order, latency of 1 or more cycles.
REQ-008 SHALL have port imem_rdata  input  16  returned instruction word.
REQ-009 SHALL have port instr_valid  output  1  head queue entry available to the core.
REQ-010 SHALL have port instr_ready  input  1  core accepts the head entry this cycle.
REQ-011 SHALL have port instr  output  16  head instruction word.
REQ-012 SHALL have port instr_pc  output  16  address of the head instruction.
REQ-013 SHALL have port redirect  input  1  branch/jump taken; discard all queued and in-flight fetches.
REQ-014 SHALL have port redirect_pc  input  16  new fetch address when redirect is high.
REQ-015 SHALL have port halt  input  1  stop issuing new requests while high.

Function
REQ-016 SHALL use FSM states FETCH, DRAIN, HALTED.
REQ-017 SHALL, in FETCH, assert imem_req when queue entries plus outstanding requests < DEPTH and halt is low; fetch_pc advances by 2 per issued request, wrapping at 16'hFFFE -> 16'h0000.
REQ-018 SHALL write each imem_rvalid response into the queue tail with its issuing address; the queue never overflows, by the REQ-017 bound.
REQ-019 SHALL pop the head when instr_valid and instr_ready are both high; push and pop in the same cycle leave occupancy unchanged.
REQ-020 SHALL, on redirect, empty the queue next cycle, set fetch_pc to redirect_pc, and load drop_cnt with the outstanding request count (counting the same-cycle response as dropped).
REQ-021 SHALL enter DRAIN when drop_cnt > 0 after redirect; in DRAIN, discard imem_rvalid responses, decrement drop_cnt on each, and keep imem_req low.
REQ-022 SHALL return from DRAIN to FETCH in the cycle drop_cnt reaches 0, issuing redirect_pc in the following cycle.
REQ-023 SHALL restart DRAIN accounting when redirect arrives during DRAIN, with the latest redirect_pc winning.
REQ-024 SHALL enter HALTED when halt is high and no requests are outstanding; in HALTED, keep imem_req low, still deliver queued entries, and return to FETCH when halt is low.
REQ-025 SHALL give redirect priority over halt and over a simultaneous pop.
REQ-026 SHALL deliver the first instruction with latency = memory latency + 1 cycle from request.

Reset
REQ-027 SHALL, during rst, force state FETCH, fetch_pc RESET_PC, queue empty, drop_cnt 0, imem_req 0, instr_valid 0, instr 0, instr_pc 0.
REQ-028 SHALL make responses arriving after reset deassertion for pre-reset requests the environment's responsibility; the memory model is reset together with this block.
REQ-029 SHALL issue the first request in the first clock edge after rst deasserts.

Configuration
REQ-030 SHALL, with FETCH_PERF_CNT_EN defined, add outputs stall_cnt (16, counts cycles with instr_ready high and instr_valid low, saturating at 16'hFFFF) and flush_cnt (16, counts redirects, saturating), both reset to 0.
REQ-031 SHALL, without FETCH_PERF_CNT_EN defined, omit both counter ports and their logic entirely.

Structure
REQ-032 SHALL place the FSM state encoding, the PC increment constant (2), and the reset PC default in shared package mips_pkg.
REQ-033 SHALL implement the queue as sub-module fetch_queue (DEPTH x 32-bit {pc, instr}, push/pop/flush, count output).

Verification
REQ-034 SHALL cover: reset release with 1-cycle memory and instr_ready=1 -> instr_pc sequence 0,2,4,6, first instr_valid 2 cycles after reset release.
REQ-035 SHALL cover: instr_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests issued, imem_req low thereafter, no data lost on resume.
REQ-036 SHALL cover: 3-cycle memory latency, redirect to 16'h0100 with 3 outstanding requests -> 3 responses dropped, next instr_pc 16'h0100, no stale instruction delivered.
REQ-037 SHALL cover: second redirect to 16'h0200 during DRAIN -> first delivered instr_pc is 16'h0200.
REQ-038 SHALL cover: RESET_PC=16'hFFFC -> delivered instr_pc sequence FFFC, FFFE, 0000.
REQ-039 SHALL cover: halt high with 2 queued entries -> both delivered, no new requests issued; on halt release, fetch resumes at the next sequential PC.
